// File: rtl/vdp_pkg.sv
// Shared VDP types: VRAM requester identifiers and VRAM arbiter FSM states.
package vdp_pkg;

  localparam int VRAM_ADDR_W = 14;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_SPR  = 2'd1,
    REQ_BG   = 2'd2,
    REQ_CPU  = 2'd3
  } vram_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RETURN = 2'd2
  } vram_arb_state_t;

endpackage

// File: rtl/vdp_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module vdp_sat_counter #(
  parameter int W   = 5,
  parameter int MAX = 16
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)                          count <= '0;
    else if (clr)                        count <= '0;
    else if (inc && (count != W'(MAX)))  count <= count + W'(1);
  end

endmodule

// File: rtl/vdp_vram_prio_sel.sv
// Combinational VRAM winner select: spr > bg > cpu, CPU first when forced.
module vdp_vram_prio_sel
  import vdp_pkg::*;
(
  input  logic      spr_req,
  input  logic      bg_req,
  input  logic      cpu_req,
  input  vram_req_t mask,
  input  logic      cpu_force,
  output vram_req_t win
);

  logic spr_ok, bg_ok, cpu_ok;

  assign spr_ok = spr_req && (mask != REQ_SPR);
  assign bg_ok  = bg_req  && (mask != REQ_BG);
  assign cpu_ok = cpu_req && (mask != REQ_CPU);

  always_comb begin
    win = REQ_NONE;
    if (cpu_force && cpu_ok) win = REQ_CPU;
    else if (spr_ok)         win = REQ_SPR;
    else if (bg_ok)          win = REQ_BG;
    else if (cpu_ok)         win = REQ_CPU;
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Single-port VRAM arbiter: sprite, background and CPU share one byte access
// per two cycles; a starved CPU request is forced through after CPU_MAX_WAIT.
module vdp_vram_arbiter
  import vdp_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              spr_req,
  input  logic [ADDR_W-1:0] spr_addr,
  output logic              spr_ack,
  input  logic              bg_req,
  input  logic [ADDR_W-1:0] bg_addr,
  output logic              bg_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_we,
  output logic [DATA_W-1:0] vram_wdata,
  input  logic [DATA_W-1:0] vram_rdata,
  output logic              busy
);

  localparam int WAIT_W = $clog2(CPU_MAX_WAIT + 1);

  vram_arb_state_t   state, state_nxt;
  vram_req_t         win, owner, mask;
  logic              arb_en, grant, cpu_force;
  logic              wait_clr, wait_inc;
  logic [WAIT_W-1:0] cpu_wait;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;

  vdp_vram_prio_sel u_prio (
    .spr_req   (spr_req),
    .bg_req    (bg_req),
    .cpu_req   (cpu_req),
    .mask      (mask),
    .cpu_force (cpu_force),
    .win       (win)
  );

  assign cpu_force = (cpu_wait == WAIT_W'(CPU_MAX_WAIT));
  assign grant     = arb_en && (win != REQ_NONE);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // RETURN is also an arbitration point, with the just-served requester masked.
  always_comb begin
    state_nxt = state;
    arb_en    = 1'b0;
    mask      = REQ_NONE;
    unique case (state)
      ARB_IDLE: begin
        arb_en = 1'b1;
        if (win != REQ_NONE) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: state_nxt = ARB_RETURN;
      ARB_RETURN: begin
        arb_en    = 1'b1;
        mask      = owner;
        state_nxt = (win != REQ_NONE) ? ARB_ACCESS : ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Owner drops to NONE when the FSM goes idle so the wait counter runs freely.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      owner     <= REQ_NONE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else if (grant) begin
      owner  <= win;
      lat_we <= (win == REQ_CPU) && cpu_we;
      unique case (win)
        REQ_SPR: lat_addr <= spr_addr;
        REQ_BG:  lat_addr <= bg_addr;
        default: lat_addr <= cpu_addr;
      endcase
      if (win == REQ_CPU) lat_wdata <= cpu_wdata;
    end else if (state == ARB_RETURN) begin
      owner <= REQ_NONE;
    end
  end

  assign wait_clr = !cpu_req || (grant && (win == REQ_CPU));
  assign wait_inc = cpu_req && (owner != REQ_CPU);

  vdp_sat_counter #(
    .W   (WAIT_W),
    .MAX (CPU_MAX_WAIT)
  ) u_cpu_wait (
    .clk   (clk),
    .rst_L (rst_L),
    .clr   (wait_clr),
    .inc   (wait_inc),
    .count (cpu_wait)
  );

  assign busy       = (state != ARB_IDLE);
  assign vram_addr  = lat_addr;
  assign vram_wdata = lat_wdata;
  assign vram_we    = (state == ARB_ACCESS) && lat_we;
  assign spr_ack    = (state == ARB_RETURN) && (owner == REQ_SPR);
  assign bg_ack     = (state == ARB_RETURN) && (owner == REQ_BG);
  assign cpu_ack    = (state == ARB_RETURN) && (owner == REQ_CPU);
  assign rdata      = (state == ARB_RETURN) ? vram_rdata : '0;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Bench for vdp_vram_arbiter: VRAM memory model, slot-level reference model,
// per-cycle compare, directed scenarios and randomized requester traffic.
module tb_vdp_vram_arbiter;

  localparam int AW   = 14;
  localparam int DW   = 8;
  localparam int MAXW = 16;

  logic          clk = 1'b0;
  logic          rst_L = 1'b0;
  logic          spr_req = 1'b0, bg_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] spr_addr = '0, bg_addr = '0, cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          spr_ack, bg_ack, cpu_ack, vram_we, busy;
  logic [DW-1:0] rdata, vram_wdata;
  logic [DW-1:0] vram_rdata;
  logic [AW-1:0] vram_addr;

  int n_cmp = 0;
  int n_err = 0;

  vdp_vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CPU_MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_L(rst_L),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack),
    .bg_req(bg_req), .bg_addr(bg_addr), .bg_ack(bg_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .rdata(rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_byte(input logic [AW-1:0] a);
    if (a == 14'h3F00) return 8'h5A;
    return a[7:0] ^ {a[13:8], 2'b01};
  endfunction

  // VRAM macro: registered read, one cycle after the address.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= init_byte(AW'(i));
      vram_rdata <= '0;
    end else begin
      if (vram_we) mem[vram_addr] <= vram_wdata;
      vram_rdata <= mem[vram_addr];
    end
  end

  // Reference: 0 = free slot, 1 = address phase, 2 = data/ack phase.
  // who: 0 none, 1 sprite, 2 background, 3 cpu.
  int            m_phase, m_who, m_wait, nxt_w;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  function automatic int pick(input logic s, input logic b, input logic c,
                              input int masked, input bit force_cpu);
    if (c && masked != 3 && force_cpu) return 3;
    if (s && masked != 1) return 1;
    if (b && masked != 2) return 2;
    if (c && masked != 3) return 3;
    return 0;
  endfunction

  always_comb begin
    nxt_w = 0;
    if (m_phase != 1)
      nxt_w = pick(spr_req, bg_req, cpu_req, (m_phase == 2) ? m_who : 0, m_wait == MAXW);
  end

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      m_phase <= 0; m_who <= 0; m_wait <= 0;
      m_we <= 1'b0; m_addr <= '0; m_wdata <= '0;
      for (int i = 0; i < (1<<AW); i++) ref_mem[i] <= init_byte(AW'(i));
    end else begin
      if (m_phase == 1) begin
        m_phase <= 2;
        if (m_we) ref_mem[m_addr] <= m_wdata;
      end else if (nxt_w != 0) begin
        m_phase <= 1;
        m_who   <= nxt_w;
        m_addr  <= (nxt_w == 1) ? spr_addr : (nxt_w == 2) ? bg_addr : cpu_addr;
        m_we    <= (nxt_w == 3) && cpu_we;
        if (nxt_w == 3) m_wdata <= cpu_wdata;
      end else begin
        m_phase <= 0;
        m_who   <= 0;
      end
      if (!cpu_req || nxt_w == 3) m_wait <= 0;
      else if (!(m_phase != 0 && m_who == 3) && m_wait < MAXW) m_wait <= m_wait + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("busy",    32'(busy),    32'(m_phase != 0));
    chk("spr_ack", 32'(spr_ack), 32'(m_phase == 2 && m_who == 1));
    chk("bg_ack",  32'(bg_ack),  32'(m_phase == 2 && m_who == 2));
    chk("cpu_ack", 32'(cpu_ack), 32'(m_phase == 2 && m_who == 3));
    chk("vram_we", 32'(vram_we), 32'(m_phase == 1 && m_we));
    if (m_phase == 1) chk("vram_addr", 32'(vram_addr), 32'(m_addr));
    if (m_phase == 1 && m_we) chk("vram_wdata", 32'(vram_wdata), 32'(m_wdata));
    if (m_phase == 2 && !m_we) chk("rdata", 32'(rdata), 32'(ref_mem[m_addr]));
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic step_req(input logic req, input logic ack, input int d,
                          output logic req_n, output logic load);
    load  = 1'b0;
    req_n = req;
    if (req && ack) begin
      req_n = (d == 2) || ($urandom_range(0, 2) == 0);
      load  = 1'b1;
    end else if (req) begin
      if (d != 2 && $urandom_range(0, 50) == 0) req_n = 1'b0;
      else if ($urandom_range(0, 20) == 0)      load  = 1'b1;
    end else begin
      req_n = (d == 2) || ($urandom_range(0, (d == 0) ? 5 : 1) == 0);
      load  = req_n;
    end
  endtask

  int   dens;
  logic sa, ba, ca, r, ld;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vram_addr",  32'(vram_addr),  32'h0);
    chk("rst_vram_wdata", 32'(vram_wdata), 32'h0);
    chk("rst_vram_we",    32'(vram_we),    32'h0);
    chk("rst_busy",       32'(busy),       32'h0);
    chk("rst_acks",       32'({spr_ack, bg_ack, cpu_ack}), 32'h0);
    tick; rst_L = 1'b1;
    tick;

    // Single background read of a preloaded byte
    bg_req = 1'b1; bg_addr = 14'h3F00;
    @(negedge clk); chk("t1_idle_busy", 32'(busy), 32'h0);
    tick; bg_req = 1'b0;
    @(negedge clk); chk("t1_vram_addr", 32'(vram_addr), 32'h3F00);
    tick; @(negedge clk);
    chk("t1_bg_ack", 32'(bg_ack), 32'h1);
    chk("t1_rdata",  32'(rdata),  32'h5A);
    tick; @(negedge clk); chk("t1_back_idle", 32'(busy), 32'h0);

    // Sprite and background together
    tick; spr_req = 1'b1; spr_addr = 14'h3F80; bg_req = 1'b1; bg_addr = 14'h2000;
    tick; tick; @(negedge clk);
    chk("t2_spr_ack", 32'({spr_ack, bg_ack}), 32'b10);
    tick; spr_req = 1'b0;
    tick; @(negedge clk);
    chk("t2_bg_ack", 32'({spr_ack, bg_ack}), 32'b01);
    tick; bg_req = 1'b0;
    @(negedge clk); chk("t2_idle", 32'(busy), 32'h0);

    // CPU write then read back
    tick; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'hA5;
    tick; @(negedge clk);
    chk("t3_we",    32'(vram_we),    32'h1);
    chk("t3_addr",  32'(vram_addr),  32'h1234);
    chk("t3_wdata", 32'(vram_wdata), 32'hA5);
    tick; @(negedge clk);
    chk("t3_wr_ack", 32'(cpu_ack), 32'h1);
    chk("t3_we_one", 32'(vram_we), 32'h0);
    tick; cpu_req = 1'b0;
    tick; cpu_req = 1'b1; cpu_we = 1'b0;
    tick; tick; @(negedge clk);
    chk("t3_rd_ack",   32'(cpu_ack), 32'h1);
    chk("t3_rd_rdata", 32'(rdata),   32'hA5);
    tick; cpu_req = 1'b0;
    tick;

    // Starvation: sprite and background saturate the port
    spr_req = 1'b1; spr_addr = 14'h0011; bg_req = 1'b1; bg_addr = 14'h0022;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1234;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      chk("t4_cpu_ack", 32'(cpu_ack), 32'(c == 18));
      if (c == 18) chk("t4_rdata", 32'(rdata), 32'hA5);
      tick;
    end
    cpu_req = 1'b0; spr_req = 1'b0; bg_req = 1'b0;
    repeat (4) tick;
    @(negedge clk); chk("t4_idle", 32'(busy), 32'h0);

    // Request dropped after grant
    tick; bg_req = 1'b1; bg_addr = 14'h0040;
    tick; bg_req = 1'b0;
    tick; @(negedge clk); chk("t6_bg_ack", 32'(bg_ack), 32'h1);
    tick; @(negedge clk); chk("t6_idle0", 32'(busy), 32'h0);
    tick; @(negedge clk); chk("t6_idle1", 32'(busy), 32'h0);

    // Randomized traffic; dens 2 keeps sprite/background saturated
    dens = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) dens = $urandom_range(0, 2);
      @(negedge clk); sa = spr_ack; ba = bg_ack; ca = cpu_ack;
      tick;
      step_req(spr_req, sa, dens, r, ld);
      spr_req = r; if (ld) spr_addr = AW'($urandom_range(0, 63));
      step_req(bg_req, ba, dens, r, ld);
      bg_req = r;  if (ld) bg_addr = AW'($urandom_range(0, 63));
      step_req(cpu_req, ca, dens, r, ld);
      cpu_req = r;
      if (ld) begin
        cpu_addr  = AW'($urandom_range(0, 63));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_wdata = DW'($urandom);
      end
    end
    spr_req = 1'b0; bg_req = 1'b0; cpu_req = 1'b0;
    repeat (6) tick;

    // Reset during a CPU write access
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0777; cpu_wdata = 8'h3C;
    tick;
    chk("t5_we_before", 32'(vram_we), 32'h1);
    rst_L = 1'b0; #1;
    chk("t5_we_rst",   32'(vram_we), 32'h0);
    chk("t5_acks_rst", 32'({spr_ack, bg_ack, cpu_ack}), 32'h0);
    chk("t5_busy_rst", 32'(busy), 32'h0);
    cpu_req = 1'b0;
    tick; tick; rst_L = 1'b1;
    @(negedge clk); chk("t5_idle_after", 32'(busy), 32'h0);

    // Reset during the ack cycle
    tick; spr_req = 1'b1; spr_addr = 14'h0005;
    tick; tick;
    chk("t5_spr_ack_before", 32'(spr_ack), 32'h1);
    rst_L = 1'b0; #1;
    chk("t5_spr_ack_rst", 32'(spr_ack), 32'h0);
    chk("t5_busy_rst2",   32'(busy),    32'h0);
    spr_req = 1'b0;
    tick; rst_L = 1'b1;
    tick; @(negedge clk); chk("t5_idle_after2", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
